// File: rtl/rf_wb_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rf_wb_arbiter_pkg
// Description : Shared register-file widths and the writeback request type.
// Revision    : 1.0
// ============================================================================
package rf_wb_arbiter_pkg;

    localparam int RF_AW    = 5;
    localparam int RF_DW    = 32;
    localparam int RF_NREGS = 32;

    typedef struct packed {
        logic             valid;
        logic [RF_AW-1:0] addr;
        logic [RF_DW-1:0] data;
    } wb_req_t;

endpackage
`default_nettype wire

// File: rtl/wb_skid_buf.sv
`default_nettype none
// ============================================================================
// Module      : wb_skid_buf
// Description : One-entry writeback holding buffer with valid/ready accept
//               and a drain input that frees the slot on the same edge.
// Revision    : 1.0
// ============================================================================
module wb_skid_buf
    import rf_wb_arbiter_pkg::*;
#(
    parameter int DW = RF_DW,
    parameter int AW = RF_AW
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [AW-1:0] in_addr,
    input  logic [DW-1:0] in_data,
    input  logic          drain,
    output logic          buf_valid,
    output logic [AW-1:0] buf_addr,
    output logic [DW-1:0] buf_data
);

    logic          r_valid;
    logic [AW-1:0] r_addr;
    logic [DW-1:0] r_data;
    logic          w_accept;

    // A slot being drained this cycle can take a new entry on the same edge.
    assign in_ready = !r_valid || drain;
    assign w_accept = in_valid && in_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_valid <= 1'b0;
            r_addr  <= '0;
            r_data  <= '0;
        end else if (w_accept) begin
            r_valid <= 1'b1;
            r_addr  <= in_addr;
            r_data  <= in_data;
        end else if (drain) begin
            r_valid <= 1'b0;
        end
    end

    assign buf_valid = r_valid;
    assign buf_addr  = r_addr;
    assign buf_data  = r_data;

endmodule
`default_nettype wire

// File: rtl/rf_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rf_wb_arbiter
// Description : Arbitrates ALU (A) and load (B) writebacks onto the single
//               register-file write port with ordering and anti-starvation.
// Revision    : 1.0
// ============================================================================
module rf_wb_arbiter
    import rf_wb_arbiter_pkg::*;
#(
    parameter int DW         = RF_DW,
    parameter int AW         = RF_AW,
    parameter int STARVE_MAX = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              a_valid,
    output logic              a_ready,
    input  logic [AW-1:0]     a_addr,
    input  logic [DW-1:0]     a_data,
    input  logic              b_valid,
    output logic              b_ready,
    input  logic [AW-1:0]     b_addr,
    input  logic [DW-1:0]     b_data,
    output logic [DW-1:0]     rf_d,
    output logic [AW-1:0]     rf_d_addr,
    output logic              rf_d_en,
    output logic [2**AW-1:0]  pend_mask,
    output logic              a_starved
);

    localparam int c_starve_w = $clog2(STARVE_MAX + 1);
    localparam logic [c_starve_w-1:0] c_starve_max = c_starve_w'(STARVE_MAX);

    logic          w_a_v, w_b_v;
    logic [AW-1:0] w_a_addr, w_b_addr;
    logic [DW-1:0] w_a_data, w_b_data;
    logic          w_grant_a, w_grant_b;
    logic          w_a_held, w_b_held;
    logic          w_a_older_nxt;
    logic          r_a_older;
    logic [c_starve_w-1:0] r_starve;
    logic [2**AW-1:0]      w_pend;

    wb_skid_buf #(.DW(DW), .AW(AW)) u_buf_a (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (a_valid),
        .in_ready  (a_ready),
        .in_addr   (a_addr),
        .in_data   (a_data),
        .drain     (w_grant_a),
        .buf_valid (w_a_v),
        .buf_addr  (w_a_addr),
        .buf_data  (w_a_data)
    );

    wb_skid_buf #(.DW(DW), .AW(AW)) u_buf_b (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (b_valid),
        .in_ready  (b_ready),
        .in_addr   (b_addr),
        .in_data   (b_data),
        .drain     (w_grant_b),
        .buf_valid (w_b_v),
        .buf_addr  (w_b_addr),
        .buf_data  (w_b_data)
    );

    assign a_starved = (r_starve >= c_starve_max);

    // Same register: age decides, so program order is kept. Otherwise loads
    // win unless A has lost often enough to take over.
    always_comb begin
        w_grant_a = 1'b0;
        w_grant_b = 1'b0;
        if (w_a_v && !w_b_v) begin
            w_grant_a = 1'b1;
        end else if (w_b_v && !w_a_v) begin
            w_grant_b = 1'b1;
        end else if (w_a_v && w_b_v) begin
            if (w_a_addr == w_b_addr) begin
                w_grant_a = r_a_older;
                w_grant_b = !r_a_older;
            end else begin
                w_grant_a = a_starved;
                w_grant_b = !a_starved;
            end
        end
    end

    always_comb begin
        rf_d      = '0;
        rf_d_addr = '0;
        rf_d_en   = 1'b0;
        if (w_grant_a) begin
            rf_d      = w_a_data;
            rf_d_addr = w_a_addr;
            rf_d_en   = (w_a_addr != '0);
        end else if (w_grant_b) begin
            rf_d      = w_b_data;
            rf_d_addr = w_b_addr;
            rf_d_en   = (w_b_addr != '0);
        end
    end

    // Whichever entry survives the edge is older than anything newly accepted.
    assign w_a_held = w_a_v && !w_grant_a;
    assign w_b_held = w_b_v && !w_grant_b;

    always_comb begin
        w_a_older_nxt = 1'b1;
        if (w_a_held && w_b_held) begin
            w_a_older_nxt = r_a_older;
        end else if (w_b_held) begin
            w_a_older_nxt = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_a_older <= 1'b0;
            r_starve  <= '0;
        end else begin
            r_a_older <= w_a_older_nxt;
            if (!w_a_v || w_grant_a) begin
                r_starve <= '0;
            end else if (w_grant_b && (r_starve < c_starve_max)) begin
                r_starve <= r_starve + 1'b1;
            end
        end
    end

    always_comb begin
        w_pend = '0;
        if (w_a_v && (w_a_addr != '0)) begin
            w_pend[w_a_addr] = 1'b1;
        end
        if (w_b_v && (w_b_addr != '0)) begin
            w_pend[w_b_addr] = 1'b1;
        end
    end

    assign pend_mask = w_pend;

endmodule
`default_nettype wire

// File: tb/tb_rf_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_rf_wb_arbiter
// Description : Scoreboard bench for rf_wb_arbiter with a sequence-numbered
//               reference model and randomized traffic.
// Revision    : 1.0
// ============================================================================
module tb_rf_wb_arbiter;
    import rf_wb_arbiter_pkg::*;

    logic              clk = 1'b0;
    logic              reset;
    logic              a_valid, b_valid;
    logic              a_ready, b_ready;
    logic [RF_AW-1:0]  a_addr, b_addr;
    logic [RF_DW-1:0]  a_data, b_data;
    logic [RF_DW-1:0]  rf_d;
    logic [RF_AW-1:0]  rf_d_addr;
    logic              rf_d_en;
    logic [RF_NREGS-1:0] pend_mask;
    logic              a_starved;

    rf_wb_arbiter #(.DW(RF_DW), .AW(RF_AW), .STARVE_MAX(3)) dut (
        .clk       (clk),
        .reset     (reset),
        .a_valid   (a_valid),
        .a_ready   (a_ready),
        .a_addr    (a_addr),
        .a_data    (a_data),
        .b_valid   (b_valid),
        .b_ready   (b_ready),
        .b_addr    (b_addr),
        .b_data    (b_data),
        .rf_d      (rf_d),
        .rf_d_addr (rf_d_addr),
        .rf_d_en   (rf_d_en),
        .pend_mask (pend_mask),
        .a_starved (a_starved)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    endtask

    // Reference model: each held entry carries an acceptance sequence number.
    wb_req_t     ma, mb;
    int unsigned ma_seq, mb_seq, seq_ctr;
    int          starve;
    int          grant;      // 0 none, 1 A, 2 B
    logic        acc_a, acc_b;
    wb_req_t     exp_q[$];
    logic [RF_DW-1:0] dut_rf [RF_NREGS];

    task automatic model_reset();
        ma = '0; mb = '0; starve = 0; grant = 0; seq_ctr = 0;
    endtask

    task automatic model_check();
        logic [RF_NREGS-1:0] m_pend;
        wb_req_t w;
        grant = 0;
        if (ma.valid && !mb.valid) grant = 1;
        else if (mb.valid && !ma.valid) grant = 2;
        else if (ma.valid && mb.valid) begin
            if (ma.addr == mb.addr) grant = (ma_seq < mb_seq) ? 1 : 2;
            else grant = (starve >= 3) ? 1 : 2;
        end
        m_pend = '0;
        if (ma.valid && ma.addr != 0) m_pend[ma.addr] = 1'b1;
        if (mb.valid && mb.addr != 0) m_pend[mb.addr] = 1'b1;
        chk("a_ready", a_ready, !ma.valid || grant == 1);
        chk("b_ready", b_ready, !mb.valid || grant == 2);
        chk("pend_mask", pend_mask, m_pend);
        chk("a_starved", a_starved, starve >= 3);
        acc_a = a_valid && (!ma.valid || grant == 1);
        acc_b = b_valid && (!mb.valid || grant == 2);
        w = (grant == 1) ? ma : mb;
        if (grant != 0 && w.addr != 0) exp_q.push_back(w);
    endtask

    task automatic model_update();
        logic a_was_valid;
        a_was_valid = ma.valid;
        if (grant == 1) ma.valid = 1'b0;
        if (grant == 2) mb.valid = 1'b0;
        if (!a_was_valid || grant == 1) starve = 0;
        else if (grant == 2 && starve < 3) starve++;
        // A takes its number first, so same-edge accepts make A older.
        if (acc_a) begin ma = '{1'b1, a_addr, a_data}; ma_seq = seq_ctr++; end
        if (acc_b) begin mb = '{1'b1, b_addr, b_data}; mb_seq = seq_ctr++; end
    endtask

    // Called at posedge+1; holds the inputs for one full cycle.
    task automatic step(input logic av, input logic [RF_AW-1:0] aa, input logic [RF_DW-1:0] ad,
                        input logic bv, input logic [RF_AW-1:0] ba, input logic [RF_DW-1:0] bd);
        a_valid = av; a_addr = aa; a_data = ad;
        b_valid = bv; b_addr = ba; b_data = bd;
        @(negedge clk);
        model_check();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, '0, '0, 1'b0, '0, '0);
    endtask

    // Monitor: every write on the port must match the oldest predicted write.
    initial begin
        forever begin
            @(negedge clk);
            #1;
            if (!reset && rf_d_en) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_write", {27'd0, rf_d_addr, rf_d}, 64'd0);
                end else begin
                    wb_req_t e;
                    e = exp_q.pop_front();
                    chk("wr_addr", rf_d_addr, e.addr);
                    chk("wr_data", rf_d, e.data);
                end
                dut_rf[rf_d_addr] = rf_d;
            end
        end
    end

    initial begin
        reset = 1'b1;
        a_valid = 0; a_addr = '0; a_data = '0;
        b_valid = 0; b_addr = '0; b_data = '0;
        for (int i = 0; i < RF_NREGS; i++) dut_rf[i] = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_rf_d_en", rf_d_en, 1'b0);
        chk("rst_rf_d", rf_d, '0);
        chk("rst_rf_d_addr", rf_d_addr, '0);
        chk("rst_pend", pend_mask, '0);
        chk("rst_a_ready", a_ready, 1'b1);
        chk("rst_b_ready", b_ready, 1'b1);
        chk("rst_a_starved", a_starved, 1'b0);
        reset = 1'b0;

        // A only
        step(1'b1, 5'd5, 32'h1234, 1'b0, '0, '0);
        idle(2);

        // Simultaneous A/B, different registers
        step(1'b1, 5'd3, 32'hA, 1'b1, 5'd4, 32'hB);
        idle(3);

        // Same-register ordering behind an earlier B
        step(1'b1, 5'd7, 32'h1, 1'b1, 5'd2, 32'hB0);
        step(1'b0, '0, '0, 1'b1, 5'd7, 32'h2);
        idle(3);
        chk("reg7_final", dut_rf[7], 32'h2);

        // Starvation: B streams distinct registers while A waits on r9
        step(1'b1, 5'd9, 32'h99, 1'b1, 5'd10, 32'h100);
        for (int i = 0; i < 6; i++) step(1'b0, '0, '0, 1'b1, 5'(11 + i), 32'(i));
        idle(2);
        chk("reg9_written", dut_rf[9], 32'h99);

        // Address 0 drains without a write
        step(1'b0, '0, '0, 1'b1, 5'd0, 32'hFFFF);
        idle(2);

        // Reset with both buffers full discards them
        step(1'b1, 5'd20, 32'hDEAD, 1'b1, 5'd21, 32'hBEEF);
        reset = 1'b1; a_valid = 0; b_valid = 0;
        #1;
        chk("mid_rst_en", rf_d_en, 1'b0);
        chk("mid_rst_pend", pend_mask, '0);
        chk("mid_rst_a_ready", a_ready, 1'b1);
        chk("mid_rst_b_ready", b_ready, 1'b1);
        model_reset();
        @(posedge clk);
        #1;
        reset = 1'b0;
        idle(3);
        chk("reg20_untouched", dut_rf[20], 32'h0);
        chk("reg21_untouched", dut_rf[21], 32'h0);

        // Randomized traffic on a small register range
        for (int i = 0; i < 1500; i++) begin
            step($urandom_range(0, 99) < 60, 5'($urandom_range(0, 7)), $urandom,
                 $urandom_range(0, 99) < 80, 5'($urandom_range(0, 7)), $urandom);
        end
        idle(4);
        chk("queue_empty", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
